// File: rtl/pdp8_pkg.sv
// Shared PDP-8 types and defaults: write transaction layout, scoreboard event
// identifiers and the EXEC write-scoreboard default sizing.
package pdp8_pkg;

  localparam int PDP8_ADDR_W    = 12;
  localparam int PDP8_DATA_W    = 12;
  localparam int SB_DEPTH       = 4;
  localparam int SB_TIMEOUT_CYC = 16;
  localparam int SB_NUM_EV      = 6;

  typedef struct packed {
    logic [PDP8_ADDR_W-1:0] addr;
    logic [PDP8_DATA_W-1:0] data;
  } wr_txn_s;

  // Event order doubles as the bit index of the scoreboard's event vector
  typedef enum logic [2:0] {
    SB_MATCH,
    SB_MISMATCH,
    SB_UNEXPECTED,
    SB_OVERFLOW,
    SB_TIMEOUT,
    SB_RD_STUCK
  } sb_event_e;

endpackage

// File: rtl/sb_fifo.sv
// Parametrised synchronous FIFO holding expected write transactions.
// Occupancy is counted separately from the pointers so full and empty differ.
module sb_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       din,
  output logic [$clog2(DEPTH):0] count,
  output logic [WIDTH-1:0]       head,
  output logic                   empty,
  output logic                   full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

endmodule

// File: rtl/exec_wr_scoreboard.sv
// In-order scoreboard for the PDP-8 EXEC memory-write path: compares DUT writes
// against golden-model expectations and watches for timeouts and stuck reads.
module exec_wr_scoreboard
  import pdp8_pkg::*;
#(
  parameter int ADDR_W     = PDP8_ADDR_W,
  parameter int DATA_W     = PDP8_DATA_W,
  parameter int DEPTH      = SB_DEPTH,
  parameter int TIMEOUT    = SB_TIMEOUT_CYC,
  parameter int MAX_RD_CYC = 1,
  parameter int CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     exp_valid,
  input  logic [ADDR_W-1:0]        exp_addr,
  input  logic [DATA_W-1:0]        exp_data,
  input  logic                     exec_wr_req,
  input  logic [ADDR_W-1:0]        exec_wr_addr,
  input  logic [DATA_W-1:0]        exec_wr_data,
  input  logic                     exec_rd_req,
  input  logic                     chk_addr_en,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     ev_match,
  output logic                     ev_mismatch,
  output logic                     ev_unexpected,
  output logic                     ev_overflow,
  output logic                     ev_timeout,
  output logic                     ev_rd_stuck,
  output logic                     err_sticky,
  output logic [CNT_W-1:0]         match_cnt,
  output logic [CNT_W-1:0]         mismatch_cnt,
  output logic [ADDR_W+DATA_W-1:0] last_exp,
  output logic [ADDR_W+DATA_W-1:0] last_got
);

  localparam int TXN_W = ADDR_W + DATA_W;
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int RD_W  = $clog2(MAX_RD_CYC + 2);
  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT);
  localparam logic [RD_W-1:0]  RD_MAX  = RD_W'(MAX_RD_CYC);
  localparam logic [RD_W-1:0]  RD_LIM  = RD_W'(MAX_RD_CYC + 1);

  logic [TXN_W-1:0]     head, exp_txn, got_txn, cmp_txn;
  logic                 empty, full;
  logic                 wr_pop, tmo_hit, fifo_pop, fifo_push;
  logic                 cmp_valid, cmp_bad, cnt_err, any_err;
  logic [TMO_W-1:0]     tmo_cnt, tmo_cnt_d;
  logic [RD_W-1:0]      rd_cnt, rd_cnt_d;
  logic [SB_NUM_EV-1:0] ev_d, ev_q;

  sb_fifo #(.WIDTH(TXN_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (flush),
    .din   (exp_txn),
    .count (pending),
    .head  (head),
    .empty (empty),
    .full  (full)
  );

  // A write against an empty queue compares straight against a same-cycle push
  always_comb begin
    exp_txn   = {exp_addr, exp_data};
    got_txn   = {exec_wr_addr, exec_wr_data};
    wr_pop    = exec_wr_req && !empty;
    tmo_hit   = !empty && !exec_wr_req && (tmo_cnt == TMO_LIM);
    fifo_pop  = !flush && (wr_pop || tmo_hit);
    fifo_push = !flush && exp_valid && !(exec_wr_req && empty) && (!full || fifo_pop);
    cmp_valid = exec_wr_req && (!empty || exp_valid);
    cmp_txn   = empty ? exp_txn : head;
    cmp_bad   = (cmp_txn[DATA_W-1:0] != exec_wr_data) ||
                (chk_addr_en && (cmp_txn[TXN_W-1:DATA_W] != exec_wr_addr));

    ev_d = '0;
    if (!flush) begin
      ev_d[SB_MATCH]      = cmp_valid && !cmp_bad;
      ev_d[SB_MISMATCH]   = cmp_valid && cmp_bad;
      ev_d[SB_UNEXPECTED] = exec_wr_req && empty && !exp_valid;
      ev_d[SB_OVERFLOW]   = exp_valid && full && !fifo_pop;
      ev_d[SB_TIMEOUT]    = tmo_hit;
      ev_d[SB_RD_STUCK]   = exec_rd_req && (rd_cnt == RD_MAX);
    end
    cnt_err = ev_d[SB_MISMATCH] | ev_d[SB_UNEXPECTED] | ev_d[SB_OVERFLOW] | ev_d[SB_TIMEOUT];
    any_err = cnt_err | ev_d[SB_RD_STUCK];

    if (flush || empty || fifo_pop) tmo_cnt_d = '0;
    else                            tmo_cnt_d = tmo_cnt + 1'b1;

    // Parking at RD_LIM keeps the stuck pulse from repeating while the strobe holds
    if (!exec_rd_req)          rd_cnt_d = '0;
    else if (rd_cnt != RD_LIM) rd_cnt_d = rd_cnt + 1'b1;
    else                       rd_cnt_d = rd_cnt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ev_q         <= '0;
      tmo_cnt      <= '0;
      rd_cnt       <= '0;
      match_cnt    <= '0;
      mismatch_cnt <= '0;
      err_sticky   <= 1'b0;
      last_exp     <= '0;
      last_got     <= '0;
    end else begin
      ev_q    <= ev_d;
      tmo_cnt <= tmo_cnt_d;
      rd_cnt  <= rd_cnt_d;
      if (ev_d[SB_MATCH] && (match_cnt != '1))  match_cnt    <= match_cnt + 1'b1;
      if (cnt_err && (mismatch_cnt != '1))      mismatch_cnt <= mismatch_cnt + 1'b1;
      if (any_err)                              err_sticky   <= 1'b1;
      if (ev_d[SB_MISMATCH]) begin
        last_exp <= cmp_txn;
        last_got <= got_txn;
      end else if (ev_d[SB_UNEXPECTED]) begin
        last_exp <= '0;
        last_got <= got_txn;
      end else if (ev_d[SB_TIMEOUT]) begin
        last_exp <= head;
      end
    end
  end

  assign ev_match      = ev_q[SB_MATCH];
  assign ev_mismatch   = ev_q[SB_MISMATCH];
  assign ev_unexpected = ev_q[SB_UNEXPECTED];
  assign ev_overflow   = ev_q[SB_OVERFLOW];
  assign ev_timeout    = ev_q[SB_TIMEOUT];
  assign ev_rd_stuck   = ev_q[SB_RD_STUCK];

endmodule

// File: tb/tb_exec_wr_scoreboard.sv
// Self-checking bench for exec_wr_scoreboard: per-cycle expected events and
// occupancy are queued with each stimulus and popped once the DUT responds.
module tb_exec_wr_scoreboard;
  import pdp8_pkg::*;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 12;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 16;

  localparam logic [5:0] E_NONE  = 6'h00;
  localparam logic [5:0] E_MATCH = 6'h01;
  localparam logic [5:0] E_MISM  = 6'h02;
  localparam logic [5:0] E_UNEXP = 6'h04;
  localparam logic [5:0] E_OVF   = 6'h08;
  localparam logic [5:0] E_TMO   = 6'h10;
  localparam logic [5:0] E_RDS   = 6'h20;

  typedef struct {
    string      tag;
    logic [5:0] ev;
    int         pend;
  } exp_rec_t;

  logic clk = 1'b0;
  logic reset;
  logic exp_valid, exec_wr_req, exec_rd_req, chk_addr_en, flush;
  logic [ADDR_W-1:0] exp_addr, exec_wr_addr;
  logic [DATA_W-1:0] exp_data, exec_wr_data;
  logic [$clog2(DEPTH):0] pending;
  logic ev_match, ev_mismatch, ev_unexpected, ev_overflow, ev_timeout, ev_rd_stuck;
  logic err_sticky;
  logic [CNT_W-1:0] match_cnt, mismatch_cnt;
  logic [ADDR_W+DATA_W-1:0] last_exp, last_got;
  logic [5:0] obs_ev;

  exp_rec_t expq[$];
  int checks   = 0;
  int failures = 0;

  exec_wr_scoreboard #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
    .TIMEOUT(16), .MAX_RD_CYC(1), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .exp_valid(exp_valid), .exp_addr(exp_addr), .exp_data(exp_data),
    .exec_wr_req(exec_wr_req), .exec_wr_addr(exec_wr_addr), .exec_wr_data(exec_wr_data),
    .exec_rd_req(exec_rd_req), .chk_addr_en(chk_addr_en), .flush(flush),
    .pending(pending),
    .ev_match(ev_match), .ev_mismatch(ev_mismatch), .ev_unexpected(ev_unexpected),
    .ev_overflow(ev_overflow), .ev_timeout(ev_timeout), .ev_rd_stuck(ev_rd_stuck),
    .err_sticky(err_sticky), .match_cnt(match_cnt), .mismatch_cnt(mismatch_cnt),
    .last_exp(last_exp), .last_got(last_got)
  );

  always #5 clk = ~clk;

  assign obs_ev = {ev_rd_stuck, ev_timeout, ev_overflow, ev_unexpected, ev_mismatch, ev_match};

  function automatic wr_txn_s txn(input logic [11:0] a, input logic [11:0] d);
    wr_txn_s t;
    t.addr = a;
    t.data = d;
    return t;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // One clock of stimulus; the expectation is queued now and checked after the edge
  task automatic applyStimulus(input string tag,
                               input logic ev, input logic [11:0] ea, input logic [11:0] ed,
                               input logic wr, input logic [11:0] wa, input logic [11:0] wd,
                               input logic rd, input logic fl,
                               input logic [5:0] exp_ev, input int exp_pend);
    exp_rec_t rec;
    exp_valid    = ev;
    exp_addr     = ea;
    exp_data     = ed;
    exec_wr_req  = wr;
    exec_wr_addr = wa;
    exec_wr_data = wd;
    exec_rd_req  = rd;
    flush        = fl;
    rec.tag  = tag;
    rec.ev   = exp_ev;
    rec.pend = exp_pend;
    expq.push_back(rec);
    @(posedge clk);
    #1;
    exp_valid   = 1'b0;
    exec_wr_req = 1'b0;
    exec_rd_req = 1'b0;
    flush       = 1'b0;
    rec = expq.pop_front();
    checkOutput({rec.tag, ".ev"}, 64'(obs_ev), 64'(rec.ev));
    checkOutput({rec.tag, ".pend"}, 64'(pending), 64'(rec.pend));
  endtask

  task automatic pushExp(input string tag, input logic [11:0] a, input logic [11:0] d,
                         input logic [5:0] exp_ev, input int exp_pend);
    applyStimulus(tag, 1'b1, a, d, 1'b0, 12'h0, 12'h0, 1'b0, 1'b0, exp_ev, exp_pend);
  endtask

  task automatic dutWrite(input string tag, input logic [11:0] a, input logic [11:0] d,
                          input logic [5:0] exp_ev, input int exp_pend);
    applyStimulus(tag, 1'b0, 12'h0, 12'h0, 1'b1, a, d, 1'b0, 1'b0, exp_ev, exp_pend);
  endtask

  task automatic idleCycles(input string tag, input int n, input int exp_pend);
    for (int i = 0; i < n; i++)
      applyStimulus(tag, 1'b0, 12'h0, 12'h0, 1'b0, 12'h0, 12'h0, 1'b0, 1'b0, E_NONE, exp_pend);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".ev"}, 64'(obs_ev), 64'(E_NONE));
    checkOutput({tag, ".pend"}, 64'(pending), 64'd0);
    checkOutput({tag, ".match_cnt"}, 64'(match_cnt), 64'd0);
    checkOutput({tag, ".mismatch_cnt"}, 64'(mismatch_cnt), 64'd0);
    checkOutput({tag, ".err_sticky"}, 64'(err_sticky), 64'd0);
    checkOutput({tag, ".last_exp"}, 64'(last_exp), 64'd0);
    checkOutput({tag, ".last_got"}, 64'(last_got), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    exp_valid = 1'b0; exec_wr_req = 1'b0; exec_rd_req = 1'b0; flush = 1'b0;
    chk_addr_en = 1'b1;
    exp_addr = '0; exp_data = '0; exec_wr_addr = '0; exec_wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset");
    reset = 1'b0;
    idleCycles("post_reset", 1, 0);

    // In-order pass
    pushExp("inord.push0", 12'h010, 12'h123, E_NONE, 1);
    pushExp("inord.push1", 12'h011, 12'h456, E_NONE, 2);
    idleCycles("inord.gap", 2, 2);
    dutWrite("inord.wr0", 12'h010, 12'h123, E_MATCH, 1);
    dutWrite("inord.wr1", 12'h011, 12'h456, E_MATCH, 0);
    checkOutput("inord.match_cnt", 64'(match_cnt), 64'd2);
    checkOutput("inord.err_sticky", 64'(err_sticky), 64'd0);

    // Data mismatch, address masking, address-only mismatch
    pushExp("mism.push", 12'h020, 12'h7FF, E_NONE, 1);
    dutWrite("mism.wr", 12'h021, 12'h7FE, E_MISM, 0);
    checkOutput("mism.last_exp", 64'(last_exp), 64'(txn(12'h020, 12'h7FF)));
    checkOutput("mism.last_got", 64'(last_got), 64'(txn(12'h021, 12'h7FE)));
    checkOutput("mism.mismatch_cnt", 64'(mismatch_cnt), 64'd1);
    checkOutput("mism.err_sticky", 64'(err_sticky), 64'd1);
    chk_addr_en = 1'b0;
    pushExp("mask.push", 12'h030, 12'h555, E_NONE, 1);
    dutWrite("mask.wr", 12'h031, 12'h555, E_MATCH, 0);
    chk_addr_en = 1'b1;
    pushExp("amism.push", 12'h040, 12'h111, E_NONE, 1);
    dutWrite("amism.wr", 12'h041, 12'h111, E_MISM, 0);
    checkOutput("amism.last_got", 64'(last_got), 64'(txn(12'h041, 12'h111)));
    checkOutput("amism.match_cnt", 64'(match_cnt), 64'd3);

    // Fill, overflow, push+pop at full, then drain in order
    pushExp("full.push0", 12'h0A0, 12'h100, E_NONE, 1);
    pushExp("full.push1", 12'h0A1, 12'h101, E_NONE, 2);
    pushExp("full.push2", 12'h0A2, 12'h102, E_NONE, 3);
    pushExp("full.push3", 12'h0A3, 12'h103, E_NONE, 4);
    pushExp("full.push4", 12'h0A4, 12'h104, E_OVF, 4);
    checkOutput("full.mismatch_cnt", 64'(mismatch_cnt), 64'd3);
    applyStimulus("full.pushpop", 1'b1, 12'h0A5, 12'h105, 1'b1, 12'h0A0, 12'h100,
                  1'b0, 1'b0, E_MATCH, 4);
    dutWrite("drain.wr1", 12'h0A1, 12'h101, E_MATCH, 3);
    dutWrite("drain.wr2", 12'h0A2, 12'h102, E_MATCH, 2);
    dutWrite("drain.wr3", 12'h0A3, 12'h103, E_MATCH, 1);
    dutWrite("drain.wr5", 12'h0A5, 12'h105, E_MATCH, 0);
    checkOutput("drain.match_cnt", 64'(match_cnt), 64'd8);

    // Bypass and unexpected write
    applyStimulus("bypass", 1'b1, 12'h050, 12'h222, 1'b1, 12'h050, 12'h222,
                  1'b0, 1'b0, E_MATCH, 0);
    dutWrite("unexp", 12'h060, 12'h333, E_UNEXP, 0);
    checkOutput("unexp.mismatch_cnt", 64'(mismatch_cnt), 64'd4);
    checkOutput("unexp.last_exp", 64'(last_exp), 64'd0);
    checkOutput("unexp.last_got", 64'(last_got), 64'(txn(12'h060, 12'h333)));

    // Timeout: expires on the 17th cycle after the push; a write that cycle wins
    pushExp("tmo.push", 12'h070, 12'h444, E_NONE, 1);
    idleCycles("tmo.wait", 16, 1);
    idleCycles("tmo.expire", 0, 0);
    applyStimulus("tmo.expire", 1'b0, 12'h0, 12'h0, 1'b0, 12'h0, 12'h0, 1'b0, 1'b0, E_TMO, 0);
    checkOutput("tmo.last_exp", 64'(last_exp), 64'(txn(12'h070, 12'h444)));
    checkOutput("tmo.mismatch_cnt", 64'(mismatch_cnt), 64'd5);
    pushExp("tmo2.push", 12'h080, 12'h555, E_NONE, 1);
    idleCycles("tmo2.wait", 16, 1);
    dutWrite("tmo2.wr", 12'h080, 12'h555, E_MATCH, 0);
    idleCycles("tmo2.after", 1, 0);
    checkOutput("tmo2.match_cnt", 64'(match_cnt), 64'd10);

    // Read strobe held three cycles: one pulse, re-armed after release
    applyStimulus("rd.c1", 1'b0, 12'h0, 12'h0, 1'b0, 12'h0, 12'h0, 1'b1, 1'b0, E_NONE, 0);
    applyStimulus("rd.c2", 1'b0, 12'h0, 12'h0, 1'b0, 12'h0, 12'h0, 1'b1, 1'b0, E_RDS, 0);
    applyStimulus("rd.c3", 1'b0, 12'h0, 12'h0, 1'b0, 12'h0, 12'h0, 1'b1, 1'b0, E_NONE, 0);
    idleCycles("rd.drop", 1, 0);
    applyStimulus("rd2.c1", 1'b0, 12'h0, 12'h0, 1'b0, 12'h0, 12'h0, 1'b1, 1'b0, E_NONE, 0);
    applyStimulus("rd2.c2", 1'b0, 12'h0, 12'h0, 1'b0, 12'h0, 12'h0, 1'b1, 1'b0, E_RDS, 0);
    checkOutput("rd.mismatch_cnt", 64'(mismatch_cnt), 64'd5);

    // Flush beats a same-cycle push; counters survive
    pushExp("fl.push0", 12'h090, 12'h010, E_NONE, 1);
    pushExp("fl.push1", 12'h091, 12'h011, E_NONE, 2);
    pushExp("fl.push2", 12'h092, 12'h012, E_NONE, 3);
    applyStimulus("fl.flush", 1'b1, 12'h093, 12'h013, 1'b0, 12'h0, 12'h0, 1'b0, 1'b1, E_NONE, 0);
    checkOutput("fl.match_cnt", 64'(match_cnt), 64'd10);
    checkOutput("fl.mismatch_cnt", 64'(mismatch_cnt), 64'd5);
    dutWrite("fl.unexp", 12'h090, 12'h010, E_UNEXP, 0);

    // Asynchronous reset while entries are queued and an event is showing
    pushExp("rst.push0", 12'h0B0, 12'h001, E_NONE, 1);
    pushExp("rst.push1", 12'h0B1, 12'h002, E_NONE, 2);
    dutWrite("rst.wr", 12'h0B0, 12'h001, E_MATCH, 1);
    reset = 1'b1;
    #2;
    checkAllZero("rst.async");
    @(posedge clk);
    #1;
    reset = 1'b0;
    idleCycles("rst.release", 2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exec_wr_scoreboard.md
Name: exec_wr_scoreboard

Overview:
- Parametrised, synthesizable scoreboard for the PDP-8 EXEC unit memory-write path.
- The golden model pushes expected write transactions (address and data) into an in-order queue.
- Each DUT write observed at the memory boundary pops the queue head and is compared against it, with per-field masking.
- Also monitors read-request stuck cycles and expected-write timeout. Reports sticky error flags plus pulsed error events and counters, for assertions and end-of-test reporting.

Parameters:
- ADDR_W, 12, address width.
- DATA_W, 12, data width.
- DEPTH, 4, expected-queue entries (power of 2, >=2).
- TIMEOUT, 16, max cycles a head entry may wait for a DUT write (>=1).
- MAX_RD_CYC, 1, max consecutive cycles exec_rd_req may stay high.
- CNT_W, 16, width of the event counters (saturating).

Ports:
- clk  in  1  free-running clock
- reset  in  1  asynchronous, active-high reset
- exp_valid  in  1  golden model pushes an expected write this cycle
- exp_addr  in  ADDR_W  expected write address
- exp_data  in  DATA_W  expected write data
- exec_wr_req  in  1  DUT write strobe, sampled at posedge
- exec_wr_addr  in  ADDR_W  DUT write address
- exec_wr_data  in  DATA_W  DUT write data
- exec_rd_req  in  1  DUT read strobe
- chk_addr_en  in  1  1 = compare address field; 0 = data only
- flush  in  1  empties the queue and clears timeout state; counters and sticky flags kept
- pending  out  $clog2(DEPTH)+1  current queue occupancy
- ev_match  out  1  one-cycle pulse: compare passed
- ev_mismatch  out  1  one-cycle pulse: compare failed
- ev_unexpected  out  1  pulse: DUT write with nothing expected
- ev_overflow  out  1  pulse: push rejected, queue full
- ev_timeout  out  1  pulse: head entry expired
- ev_rd_stuck  out  1  pulse: read strobe exceeded MAX_RD_CYC
- err_sticky  out  1  OR of all error events since reset
- match_cnt  out  CNT_W  saturating count of passes
- mismatch_cnt  out  CNT_W  saturating count of mismatch, unexpected, overflow and timeout events
- last_exp  out  ADDR_W+DATA_W  {addr,data} of the most recent failed compare's expected entry
- last_got  out  ADDR_W+DATA_W  {addr,data} of the most recent failed DUT write

Behaviour:
- Reset values: all outputs 0. Queue empty; rd-stuck counter 0; timeout counter 0.
- Latency: every ev_* output and counter update is registered, appearing on the posedge after the triggering sample.
- Push: exp_valid with pending<DEPTH writes an entry at the tail.
- Overflow: exp_valid with pending==DEPTH and no same-cycle pop drops the entry and sets ev_overflow.
- Simultaneous push and pop when full: push accepted, no overflow.
- Pop/compare: exec_wr_req with pending>0 pops the head and compares it.
  - Data always compared; address compared only if chk_addr_en.
  - Equal -> ev_match, match_cnt++.
  - Unequal -> ev_mismatch, mismatch_cnt++, last_exp/last_got captured.
- Bypass: exec_wr_req with pending==0 and exp_valid in the same cycle compares directly against the pushed values; nothing is enqueued.
- Unexpected: exec_wr_req with pending==0 and no exp_valid -> ev_unexpected. last_got is captured; last_exp is set to 0.
- Timeout: counter increments each cycle pending>0 and no pop occurs. It resets to 0 on pop, on flush, or when the queue is empty.
  - On reaching TIMEOUT: ev_timeout, head discarded, counter cleared, last_exp captured.
  - If a pop occurs in that same cycle, the pop wins and no timeout is raised.
- Rd-stuck: counter increments while exec_rd_req==1 and clears when it is 0.
  - ev_rd_stuck pulses once when the count first exceeds MAX_RD_CYC, and does not repeat until exec_rd_req drops.
  - ev_rd_stuck does not increment mismatch_cnt.
- Flush: highest priority over push and pop in that cycle. The queue is emptied; events in that cycle are suppressed.
- Pointers: wrap modulo DEPTH; occupancy is tracked separately so full and empty are distinguishable.
- Counters: saturate at all-ones, no wrap.
- err_sticky: set by any ev_* output; cleared only by reset.
- Reset mid-operation: asynchronous clear of all state; no events emitted on reset release.

Decomposition:
- Add to pdp8_pkg:
  - typedef wr_txn_s {addr, data}.
  - enum sb_event_e {SB_MATCH, SB_MISMATCH, SB_UNEXPECTED, SB_OVERFLOW, SB_TIMEOUT, SB_RD_STUCK} for bench reporting.
  - Defaults: SB_DEPTH, SB_TIMEOUT.
- One sub-module: sb_fifo, a parametrised synchronous FIFO.
  - Interface: push/pop/flush, count, head data.
  - The top holds the compare logic, timeout and rd-stuck counters, event registers and counters.

Test Plan:
- In-order pass: push (addr 0x010, data 0x123) then (0x011, 0x456); DUT writes the same pair in cycles 5 and 6 -> ev_match on cycles 6 and 7, match_cnt=2, pending=0, err_sticky=0.
- Data mismatch plus masking: push (0x020, 0x7FF); DUT writes (0x021, 0x7FE) with chk_addr_en=1 -> ev_mismatch, last_exp=0x0207FF, last_got=0x0217FE. Repeat with data equal, address differing, chk_addr_en=0 -> ev_match.
- Full and overflow: with DEPTH=4, push 5 entries with no DUT writes -> ev_overflow on the 5th, pending=4. On the next cycle push and DUT write together -> no overflow, pending stays 4.
- Bypass and unexpected: empty queue, exp_valid and exec_wr_req together with equal data -> ev_match, pending=0. Then a lone exec_wr_req -> ev_unexpected, mismatch_cnt=1.
- Timeout: TIMEOUT=16, push one entry, no writes -> ev_timeout exactly 17 cycles after the push, pending=0. A write arriving on the expiry cycle instead -> ev_match, no timeout.
- Rd-stuck, flush and reset: hold exec_rd_req for 3 cycles with MAX_RD_CYC=1 -> single ev_rd_stuck. Flush with pending=3 -> pending=0, counters kept. Assert reset mid-queue -> all outputs 0 immediately.
